// File: rtl/sram_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter for a single-ported SRAM.
// One access per IDLE->ISSUE->RESP pass, round-robin on contention.
module sram_arbiter #(
  parameter bit DATA_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_done,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_sel;
  logic        r_last_grant;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        w_any_req;
  logic        w_grant;
  logic        w_latch;
  logic        w_resp;

  // On contention the port that did not win last time is granted.
  always_comb begin
    w_any_req = inst_req | data_req;
    w_grant   = GRANT_INST;
    if (inst_req && data_req) begin
      w_grant = ~r_last_grant;
    end else if (data_req) begin
      w_grant = GRANT_DATA;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = ISSUE;
      ISSUE:   w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_latch = (r_state == IDLE) && w_any_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request-side inputs are captured once per transaction and ignored afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel        <= GRANT_INST;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_last_grant <= DATA_FIRST ? GRANT_INST : GRANT_DATA;
    end else if (w_latch) begin
      r_sel        <= w_grant;
      r_last_grant <= w_grant;
      r_we         <= (w_grant == GRANT_DATA) && data_we;
      r_addr       <= (w_grant == GRANT_DATA) ? data_addr : inst_addr;
      r_wdata      <= data_wdata;
    end
  end

  assign sram_en    = (r_state == ISSUE);
  assign sram_we    = sram_en && r_we;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;

  assign w_resp     = (r_state == RESP);
  assign inst_done  = w_resp && (r_sel == GRANT_INST);
  assign data_done  = w_resp && (r_sel == GRANT_DATA);
  assign inst_rdata = inst_done ? sram_rdata : 32'h0;
  assign data_rdata = data_done ? sram_rdata : 32'h0;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM model, scoreboard queue of expected
// completions, directed scenarios and a randomized invariant run.
module tb_sram_arbiter;

  logic        clk;
  logic        reset;
  logic        instReq;
  logic [31:0] instAddr;
  logic        instDone;
  logic [31:0] instRdata;
  logic        dataReq;
  logic        dataWe;
  logic [31:0] dataAddr;
  logic [31:0] dataWdata;
  logic        dataDone;
  logic [31:0] dataRdata;
  logic        sramEn;
  logic        sramWe;
  logic [31:0] sramAddr;
  logic [31:0] sramWdata;
  logic [31:0] sramRdata;
  logic        busy;

  typedef struct packed {
    logic        isData;
    logic        checkData;
    logic [31:0] rdata;
  } expect_t;

  expect_t     sbQueue[$];
  expect_t     exp;
  int          testsRun = 0;
  int          failCount = 0;

  logic [31:0] sramMem [0:255];
  bit          sramWritten [0:255];
  logic [31:0] refMem [0:255];
  bit          refWritten [0:255];

  sram_arbiter #(.DATA_FIRST(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_req   (instReq),
    .inst_addr  (instAddr),
    .inst_done  (instDone),
    .inst_rdata (instRdata),
    .data_req   (dataReq),
    .data_we    (dataWe),
    .data_addr  (dataAddr),
    .data_wdata (dataWdata),
    .data_done  (dataDone),
    .data_rdata (dataRdata),
    .sram_en    (sramEn),
    .sram_we    (sramWe),
    .sram_addr  (sramAddr),
    .sram_wdata (sramWdata),
    .sram_rdata (sramRdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] memIdx(input logic [31:0] a);
    return {a[28], a[8:2]};
  endfunction

  function automatic logic [31:0] defaultWord(input logic [31:0] a);
    if (a == 32'h1c00_0000) return 32'h0280_0405;
    return a ^ 32'h5a5a_5a5a;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    logic [7:0] idx;
    idx = memIdx(a);
    return refWritten[idx] ? refMem[idx] : defaultWord(a);
  endfunction

  // SRAM model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (sramEn) begin
      if (sramWe) begin
        sramMem[memIdx(sramAddr)]     <= sramWdata;
        sramWritten[memIdx(sramAddr)] <= 1'b1;
      end
      sramRdata <= sramWritten[memIdx(sramAddr)] ? sramMem[memIdx(sramAddr)] : defaultWord(sramAddr);
    end
  end

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    instReq   = iReq;
    instAddr  = iAddr;
    dataReq   = dReq;
    dataWe    = dWe;
    dataAddr  = dAddr;
    dataWdata = dWdata;
  endtask

  task automatic test_reset();
    @(negedge clk);
    testsRun++;
    if ({busy, sramEn, sramWe, instDone, dataDone} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL reset_ctl: got %b expected 00000", {busy, sramEn, sramWe, instDone, dataDone});
    end
    testsRun++;
    if ({sramAddr, sramWdata} !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL reset_bus: got addr %h wdata %h expected 0", sramAddr, sramWdata);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if ({busy, sramEn} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL idle_no_req: got %b expected 00", {busy, sramEn});
    end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    applyStimulus(1'b1, 32'h1c00_0000, 1'b0, 1'b0, 32'h0, 32'h0);
    sbQueue.push_back('{isData: 1'b0, checkData: 1'b1, rdata: 32'h0280_0405});
    @(negedge clk);
    testsRun++;
    if ({sramEn, sramWe, busy, instDone} !== 4'b1010 || sramAddr !== 32'h1c00_0000) begin
      failCount++;
      $display("[TB] FAIL fetch_issue: got en/we/busy/done %b addr %h expected 1010 1c000000",
               {sramEn, sramWe, busy, instDone}, sramAddr);
    end
    @(negedge clk);
    testsRun++;
    if ({busy, instDone, dataDone, sramEn} !== 4'b1100) begin
      failCount++;
      $display("[TB] FAIL fetch_resp: got busy/idone/ddone/en %b expected 1100", {busy, instDone, dataDone, sramEn});
    end
    if (instDone && sbQueue.size() > 0) begin
      exp = sbQueue.pop_front();
      testsRun++;
      if (exp.isData !== 1'b0 || instRdata !== exp.rdata) begin
        failCount++;
        $display("[TB] FAIL fetch_rdata: got %h expected %h", instRdata, exp.rdata);
      end
    end
    instReq = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({busy, instDone, sramEn} !== 3'b000 || instRdata !== 32'h0 || sramAddr !== 32'h1c00_0000) begin
      failCount++;
      $display("[TB] FAIL fetch_after: got busy/done/en %b rdata %h addr %h expected 000 0 1c000000",
               {busy, instDone, sramEn}, instRdata, sramAddr);
    end
    testsRun++;
    if (sbQueue.size() != 0) begin
      failCount++;
      $display("[TB] FAIL fetch_sb: got %0d pending expected 0", sbQueue.size());
    end
    sbQueue.delete();
  endtask

  task automatic test_store_load();
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 32'hdead_beef);
    sbQueue.push_back('{isData: 1'b1, checkData: 1'b0, rdata: 32'h0});
    refMem[memIdx(32'h0000_0100)]     = 32'hdead_beef;
    refWritten[memIdx(32'h0000_0100)] = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({sramEn, sramWe} !== 2'b11 || sramWdata !== 32'hdead_beef || sramAddr !== 32'h0000_0100) begin
      failCount++;
      $display("[TB] FAIL store_issue: got en/we %b addr %h wdata %h expected 11 00000100 deadbeef",
               {sramEn, sramWe}, sramAddr, sramWdata);
    end
    @(negedge clk);
    testsRun++;
    if ({dataDone, instDone} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL store_done: got %b expected 10", {dataDone, instDone});
    end
    if (dataDone && sbQueue.size() > 0) begin
      exp = sbQueue.pop_front();
      testsRun++;
      if (exp.isData !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL store_port: got data expected inst");
      end
    end
    dataReq = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    sbQueue.push_back('{isData: 1'b1, checkData: 1'b1, rdata: refRead(32'h0000_0100)});
    @(negedge clk);
    testsRun++;
    if ({sramEn, sramWe} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL load_issue: got en/we %b expected 10", {sramEn, sramWe});
    end
    @(negedge clk);
    if (dataDone && sbQueue.size() > 0) begin
      exp = sbQueue.pop_front();
      testsRun++;
      if (exp.isData !== 1'b1 || dataRdata !== exp.rdata) begin
        failCount++;
        $display("[TB] FAIL load_rdata: got %h expected %h", dataRdata, exp.rdata);
      end
    end
    dataReq = 1'b0;
    testsRun++;
    if (sbQueue.size() != 0) begin
      failCount++;
      $display("[TB] FAIL store_load_sb: got %0d pending expected 0", sbQueue.size());
    end
    sbQueue.delete();
    @(negedge clk);
  endtask

  task automatic test_contention();
    int doneCount;
    int lastDone;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 32'h1c00_0010, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    for (int k = 0; k < 2; k++) begin
      sbQueue.push_back('{isData: 1'b0, checkData: 1'b1, rdata: refRead(32'h1c00_0010)});
      sbQueue.push_back('{isData: 1'b1, checkData: 1'b1, rdata: refRead(32'h0000_0100)});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    testsRun++;
    if (sramEn !== 1'b1 || sramAddr !== 32'h1c00_0010) begin
      failCount++;
      $display("[TB] FAIL contend_first: got en %b addr %h expected 1 1c000010", sramEn, sramAddr);
    end
    doneCount = 0;
    lastDone  = 0;
    for (int c = 1; c <= 20 && doneCount < 4; c++) begin
      @(negedge clk);
      if ((instDone || dataDone) && sbQueue.size() > 0) begin
        exp = sbQueue.pop_front();
        testsRun++;
        if (dataDone !== exp.isData || instDone === dataDone ||
            (dataDone ? dataRdata : instRdata) !== exp.rdata) begin
          failCount++;
          $display("[TB] FAIL contend_grant%0d: got idone %b ddone %b rdata %h expected data=%b rdata %h",
                   doneCount, instDone, dataDone, dataDone ? dataRdata : instRdata, exp.isData, exp.rdata);
        end
        if (doneCount > 0) begin
          testsRun++;
          if (c - lastDone != 3) begin
            failCount++;
            $display("[TB] FAIL contend_gap%0d: got %0d cycles expected 3", doneCount, c - lastDone);
          end
        end
        lastDone = c;
        doneCount++;
        if (doneCount == 4) begin
          instReq = 1'b0;
          dataReq = 1'b0;
        end
      end
    end
    testsRun++;
    if (doneCount != 4) begin
      failCount++;
      $display("[TB] FAIL contend_count: got %0d dones expected 4", doneCount);
    end
    instReq = 1'b0;
    dataReq = 1'b0;
    sbQueue.delete();
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL contend_drain: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_late_request();
    @(negedge clk);
    applyStimulus(1'b1, 32'h1c00_0004, 1'b0, 1'b0, 32'h0, 32'h0);
    sbQueue.push_back('{isData: 1'b0, checkData: 1'b1, rdata: refRead(32'h1c00_0004)});
    @(negedge clk);
    applyStimulus(1'b1, 32'h1c00_0004, 1'b1, 1'b0, 32'h0000_0104, 32'h0);
    sbQueue.push_back('{isData: 1'b1, checkData: 1'b1, rdata: refRead(32'h0000_0104)});
    @(negedge clk);
    if (instDone && sbQueue.size() > 0) begin
      exp = sbQueue.pop_front();
      testsRun++;
      if (exp.isData !== 1'b0 || dataDone !== 1'b0 || instRdata !== exp.rdata) begin
        failCount++;
        $display("[TB] FAIL late_inst: got ddone %b rdata %h expected 0 %h", dataDone, instRdata, exp.rdata);
      end
    end
    instReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (sramEn !== 1'b1 || sramAddr !== 32'h0000_0104 || sramWe !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL late_issue: got en %b we %b addr %h expected 1 0 00000104", sramEn, sramWe, sramAddr);
    end
    @(negedge clk);
    testsRun++;
    if (dataDone !== 1'b1 || sbQueue.size() == 0) begin
      failCount++;
      $display("[TB] FAIL late_done: got ddone %b pending %0d expected 1 1", dataDone, sbQueue.size());
    end else begin
      exp = sbQueue.pop_front();
      testsRun++;
      if (dataRdata !== exp.rdata) begin
        failCount++;
        $display("[TB] FAIL late_rdata: got %h expected %h", dataRdata, exp.rdata);
      end
    end
    dataReq = 1'b0;
    sbQueue.delete();
    @(negedge clk);
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    applyStimulus(1'b1, 32'h1c00_0000, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (instDone !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL rstresp_pre: got idone %b expected 1", instDone);
    end
    #1 reset = 1'b1;
    #1;
    testsRun++;
    if ({instDone, dataDone, sramEn, sramWe, busy} !== 5'b0 || instRdata !== 32'h0 || sramAddr !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL rstresp_abort: got ctl %b rdata %h addr %h expected 00000 0 0",
               {instDone, dataDone, sramEn, sramWe, busy}, instRdata, sramAddr);
    end
    @(negedge clk);
    reset = 1'b0;
    sbQueue.push_back('{isData: 1'b0, checkData: 1'b1, rdata: 32'h0280_0405});
    @(negedge clk);
    testsRun++;
    if (sramEn !== 1'b1 || sramAddr !== 32'h1c00_0000) begin
      failCount++;
      $display("[TB] FAIL rstresp_issue: got en %b addr %h expected 1 1c000000", sramEn, sramAddr);
    end
    @(negedge clk);
    testsRun++;
    if (instDone !== 1'b1 || sbQueue.size() == 0) begin
      failCount++;
      $display("[TB] FAIL rstresp_done: got idone %b expected 1", instDone);
    end else begin
      exp = sbQueue.pop_front();
      testsRun++;
      if (instRdata !== exp.rdata) begin
        failCount++;
        $display("[TB] FAIL rstresp_rdata: got %h expected %h", instRdata, exp.rdata);
      end
    end
    instReq = 1'b0;
    sbQueue.delete();
    @(negedge clk);
  endtask

  task automatic test_invariants();
    bit          instPend = 1'b0;
    bit          dataPend = 1'b0;
    bit          dataW = 1'b0;
    int          instAge = 0;
    int          dataAge = 0;
    logic [31:0] instA = 32'h0;
    logic [31:0] dataA = 32'h0;
    logic [31:0] dataWd = 32'h0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      testsRun++;
      if (instDone && dataDone) begin
        failCount++;
        $display("[TB] FAIL inv_both_done: got 11 expected not both");
      end
      testsRun++;
      if (sramWe && !sramEn) begin
        failCount++;
        $display("[TB] FAIL inv_we_no_en: got we 1 en 0 expected we only with en");
      end
      testsRun++;
      if (sramWe && sramAddr[31:24] == 8'h1c) begin
        failCount++;
        $display("[TB] FAIL inv_inst_write: got write to %h expected no inst write", sramAddr);
      end
      if (instDone) begin
        testsRun++;
        if (!instPend || instRdata !== refRead(instA) || instAge > 5) begin
          failCount++;
          $display("[TB] FAIL inv_inst_done: got pend %b rdata %h age %0d expected 1 %h <=5",
                   instPend, instRdata, instAge, refRead(instA));
        end
        instPend = 1'b0;
        instReq  = 1'b0;
      end
      if (dataDone) begin
        testsRun++;
        if (!dataPend || (!dataW && dataRdata !== refRead(dataA)) || dataAge > 5) begin
          failCount++;
          $display("[TB] FAIL inv_data_done: got pend %b rdata %h age %0d expected 1 %h <=5",
                   dataPend, dataRdata, dataAge, refRead(dataA));
        end
        if (dataPend && dataW) begin
          refMem[memIdx(dataA)]     = dataWd;
          refWritten[memIdx(dataA)] = 1'b1;
        end
        dataPend = 1'b0;
        dataReq  = 1'b0;
      end
      if (instPend) instAge++;
      if (dataPend) dataAge++;
      if (!instPend && $urandom_range(0, 2) == 0) begin
        instPend = 1'b1;
        instAge  = 0;
        instA    = 32'h1c00_0000 + (32'($urandom_range(0, 7)) << 2);
        instReq  = 1'b1;
        instAddr = instA;
      end
      if (!dataPend && $urandom_range(0, 2) == 0) begin
        dataPend  = 1'b1;
        dataAge   = 0;
        dataW     = 1'($urandom_range(0, 1));
        dataA     = 32'h0000_0100 + (32'($urandom_range(0, 7)) << 2);
        dataWd    = $urandom;
        dataReq   = 1'b1;
        dataWe    = dataW;
        dataAddr  = dataA;
        dataWdata = dataWd;
      end
    end
    instReq = 1'b0;
    dataReq = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_late_request();
    test_reset_in_resp();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #200000;
    failCount++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_FIRST, default 0, meaning the data port wins the first contended arbitration after reset when 1, and the inst port wins it when 0.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port inst_req, input, 1, instruction fetch request, held until inst_done.
REQ-005 The block SHALL have port inst_addr, input, 32, fetch address, stable while inst_req=1.
REQ-006 The block SHALL have port inst_done, output, 1, one-cycle completion pulse for the fetch.
REQ-007 The block SHALL have port inst_rdata, output, 32, fetched word, valid only while inst_done=1.
REQ-008 The block SHALL have port data_req, input, 1, load/store request, held until data_done.
REQ-009 The block SHALL have port data_we, input, 1, store (1) or load (0).
REQ-010 The block SHALL have port data_addr, input, 32, load/store address.
REQ-011 The block SHALL have port data_wdata, input, 32, store data.
REQ-012 The block SHALL have port data_done, output, 1, one-cycle completion pulse for the load/store.
REQ-013 The block SHALL have port data_rdata, output, 32, load word, valid only while data_done=1.
REQ-014 The block SHALL have port sram_en, output, 1, shared SRAM access strobe.
REQ-015 The block SHALL have port sram_we, output, 1, shared SRAM write enable.
REQ-016 The block SHALL have port sram_addr, output, 32, shared SRAM address.
REQ-017 The block SHALL have port sram_wdata, output, 32, shared SRAM write data.
REQ-018 The block SHALL have port sram_rdata, input, 32, SRAM read data, valid the cycle after sram_en=1.
REQ-019 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-020 The block SHALL implement the states IDLE, ISSUE and RESP, and SHALL complete exactly one SRAM access per IDLE->ISSUE->RESP pass.
REQ-021 In IDLE with at least one request sampled, the block SHALL go to ISSUE on the next edge; with none, it SHALL stay in IDLE.
REQ-022 On the IDLE->ISSUE edge the block SHALL latch sel (the granted port), addr, wdata and we, with we forced to 0 when the inst port is granted.
REQ-023 When only one port requests, that port SHALL be granted.
REQ-024 When both ports request, the port not granted last SHALL win (round-robin on a 1-bit last_grant register).
REQ-025 The last_grant register SHALL update on every grant.
REQ-026 In ISSUE the block SHALL drive sram_en=1, sram_we = latched we, sram_addr = latched addr and sram_wdata = latched wdata, then go to RESP unconditionally.
REQ-027 Outside ISSUE, sram_en and sram_we SHALL be 0, while sram_addr and sram_wdata SHALL keep their latched values.
REQ-028 In RESP the block SHALL assert the done of the granted port only, drive that port's rdata = sram_rdata, and return to IDLE unconditionally.
REQ-029 A store SHALL still pulse data_done in RESP, and data_rdata for a store SHALL be a don't-care.
REQ-030 Whenever the corresponding done is 0, inst_rdata and data_rdata SHALL be 32'h0.
REQ-031 Latency SHALL be fixed: a request sampled at edge T gives sram_en during T..T+1 and done during T+1..T+2, i.e. 3 cycles per access with no back-to-back overlap.
REQ-032 A requester that keeps req high past the edge that ends its done cycle SHALL be treated as issuing a new request.
REQ-033 The block SHALL ignore a req rising while busy=1 until the state returns to IDLE, and SHALL NOT drop or lose it.
REQ-034 The block SHALL ignore request-side input changes after the latch edge for the rest of the transaction.
REQ-035 The block SHALL NOT produce a done without a preceding ISSUE.
REQ-036 Each done SHALL be exactly 1 cycle wide.
REQ-037 inst_done and data_done SHALL never both be 1.

Reset
REQ-038 Asserting reset SHALL immediately force state=IDLE, sram_en=0, sram_we=0, inst_done=0, data_done=0 and busy=0.
REQ-039 Asserting reset SHALL force sram_addr=0, sram_wdata=0 and last_grant=(DATA_FIRST ? inst : data).
REQ-040 Reset asserted during ISSUE or RESP SHALL abort the transaction with no done pulse, and the requester SHALL re-request after reset.
REQ-041 After reset deasserts, the first arbitration SHALL occur on the first rising edge with reset low.

Verification
REQ-042 The bench SHALL cover a single fetch: inst_req=1, inst_addr=32'h1c00_0000, SRAM word 32'h0280_0405 -> sram_en one cycle with sram_addr=32'h1c00_0000 and sram_we=0, then inst_done=1 with inst_rdata=32'h0280_0405, busy high for 2 cycles.
REQ-043 The bench SHALL cover a store: data_req=1, data_we=1, data_addr=32'h0000_0100, data_wdata=32'hdead_beef -> sram_en=1, sram_we=1, sram_wdata=32'hdead_beef; data_done pulses; a following load of 32'h0000_0100 returns 32'hdead_beef.
REQ-044 The bench SHALL cover contention with DATA_FIRST=0 and both ports requesting continuously -> grants alternate inst, data, inst, data, dones alternate every 3 cycles, and neither port starves.
REQ-045 The bench SHALL cover a late request: data_req rises while an inst access is in ISSUE -> data is granted in the first IDLE after inst_done, with no extra idle cycle.
REQ-046 The bench SHALL cover reset in RESP: reset pulses during the inst RESP cycle -> inst_done=0 immediately, sram_en=0, state=IDLE, and the next fetch completes normally in 3 cycles.
REQ-047 The bench SHALL cover invariants: the two dones are never both 1, sram_we=1 only when sram_en=1, and sram_we is never 1 for an inst grant.
